// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage - write-back stage of the 5-stage RISC pipeline.
//
// Registers the memory-stage outputs in the MEM/WB pipeline register, selects
// the write-back value (load data or ALU result), owns the architectural
// register file (two combinational read ports with same-cycle write bypass
// for the decode stage), exports write-back info for the forwarding unit and
// counts retired instructions.
//
// Ports:
//   clk                 clock, all state updates on the rising edge
//   rst                 asynchronous active-high reset
//   ReadData            load data from the memory stage
//   AluResult           ALU result passed through the memory stage
//   destination_reg     destination register index
//   wb_control_signals  {RegWrite, MemtoReg}
//   in_valid            memory stage holds a real instruction (0 = bubble)
//   stall               hold MEM/WB register, suppress commit
//   flush               load a bubble into the MEM/WB register
//   rs1_addr, rs2_addr  decode-stage read addresses
//   rs1_data, rs2_data  read data (with write bypass)
//   wb_reg_write        committing register write this cycle
//   wb_dest_reg         registered destination index
//   wb_data             selected write-back value
//   retired_count       committed instruction count (wraps)
// -----------------------------------------------------------------------------
module wb_stage #(
  parameter int word_size = 32,
  parameter int reg_size  = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [word_size-1:0] ReadData,
  input  logic [word_size-1:0] AluResult,
  input  logic [reg_size-1:0]  destination_reg,
  input  logic [1:0]           wb_control_signals,
  input  logic                 in_valid,
  input  logic                 stall,
  input  logic                 flush,
  input  logic [reg_size-1:0]  rs1_addr,
  input  logic [reg_size-1:0]  rs2_addr,
  output logic [word_size-1:0] rs1_data,
  output logic [word_size-1:0] rs2_data,
  output logic                 wb_reg_write,
  output logic [reg_size-1:0]  wb_dest_reg,
  output logic [word_size-1:0] wb_data,
  output logic [31:0]          retired_count
);

  localparam int NREGS = 1 << reg_size;

  // MEM/WB pipeline register
  logic                 valid_q,    valid_d;
  logic                 regwrite_q, regwrite_d;
  logic                 memtoreg_q, memtoreg_d;
  logic [reg_size-1:0]  dest_q,     dest_d;
  logic [word_size-1:0] rdata_q,    rdata_d;
  logic [word_size-1:0] alu_q,      alu_d;

  // Architectural state
  logic [word_size-1:0] regs_q [NREGS];
  logic [31:0]          retired_q, retired_d;

  logic                 commit;

  // Next-state for MEM/WB: flush beats stall beats capture.
  always_comb begin
    valid_d    = valid_q;
    regwrite_d = regwrite_q;
    memtoreg_d = memtoreg_q;
    dest_d     = dest_q;
    rdata_d    = rdata_q;
    alu_d      = alu_q;
    if (flush) begin
      valid_d    = 1'b0;
      regwrite_d = 1'b0;
    end else if (!stall) begin
      valid_d    = in_valid;
      regwrite_d = wb_control_signals[1] & in_valid;
      memtoreg_d = wb_control_signals[0];
      dest_d     = destination_reg;
      rdata_d    = ReadData;
      alu_d      = AluResult;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      dest_q     <= '0;
      rdata_q    <= '0;
      alu_q      <= '0;
    end else begin
      valid_q    <= valid_d;
      regwrite_q <= regwrite_d;
      memtoreg_q <= memtoreg_d;
      dest_q     <= dest_d;
      rdata_q    <= rdata_d;
      alu_q      <= alu_d;
    end
  end

  // Write-back selection and commit.
  // The instruction held in MEM/WB retires whenever it is not stalled, even
  // when a flush is discarding the incoming instruction in the same cycle.
  assign wb_data      = memtoreg_q ? rdata_q : alu_q;
  assign commit       = valid_q & ~stall;
  assign wb_reg_write = commit & regwrite_q & (dest_q != '0);
  assign wb_dest_reg  = dest_q;

  // Register file: x0 is never written since wb_reg_write excludes dest 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb_reg_write) begin
      regs_q[dest_q] <= wb_data;
    end
  end

  // Read port with write-before-read bypass so decode sees the value being
  // written at the coming edge without a stall.
  function automatic logic [word_size-1:0] read_port(input logic [reg_size-1:0] addr);
    logic [word_size-1:0] val;
    if (addr == '0) begin
      val = '0;
    end else if (wb_reg_write && (addr == dest_q)) begin
      val = wb_data;
    end else begin
      val = regs_q[addr];
    end
    return val;
  endfunction

  assign rs1_data = read_port(rs1_addr);
  assign rs2_data = read_port(rs2_addr);

  // Retired-instruction counter, natural 32-bit wrap.
  assign retired_d = retired_q + {31'd0, commit};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_q <= '0;
    end else begin
      retired_q <= retired_d;
    end
  end

  assign retired_count = retired_q;

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ReadData, AluResult;
  logic [4:0]  destination_reg;
  logic [1:0]  wb_control_signals;
  logic        in_valid, stall, flush;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic        wb_reg_write;
  logic [4:0]  wb_dest_reg;
  logic [31:0] wb_data;
  logic [31:0] retired_count;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk                (clk),
    .rst                (rst),
    .ReadData           (ReadData),
    .AluResult          (AluResult),
    .destination_reg    (destination_reg),
    .wb_control_signals (wb_control_signals),
    .in_valid           (in_valid),
    .stall              (stall),
    .flush              (flush),
    .rs1_addr           (rs1_addr),
    .rs2_addr           (rs2_addr),
    .rs1_data           (rs1_data),
    .rs2_data           (rs2_data),
    .wb_reg_write       (wb_reg_write),
    .wb_dest_reg        (wb_dest_reg),
    .wb_data            (wb_data),
    .retired_count      (retired_count)
  );

  // Behavioural model: the instruction waiting to retire, the architectural
  // register array and the retirement count.
  bit          m_valid;
  bit          m_we;
  logic [4:0]  m_dest;
  logic [31:0] m_val;
  logic [31:0] m_regs [32];
  logic [31:0] m_count;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_valid = 0; m_we = 0; m_dest = '0; m_val = '0; m_count = '0;
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
  endfunction

  function automatic bit exp_write();
    return m_valid && !stall && m_we && (m_dest != 0);
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (a == 0) return '0;
    if (exp_write() && a == m_dest) return m_val;
    return m_regs[a];
  endfunction

  // One rising edge applied to the model with the inputs present at the edge.
  function automatic void model_edge();
    if (rst) begin
      model_reset();
      return;
    end
    if (m_valid && !stall) begin
      m_count = m_count + 1;
      if (m_we && m_dest != 0) m_regs[m_dest] = m_val;
    end
    if (flush) begin
      m_valid = 0; m_we = 0;
    end else if (!stall) begin
      m_valid = in_valid;
      m_we    = wb_control_signals[1] && in_valid;
      m_dest  = destination_reg;
      m_val   = wb_control_signals[0] ? ReadData : AluResult;
    end
  endfunction

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("wb_reg_write", {31'd0, wb_reg_write}, {31'd0, exp_write()});
      chk("rs1_data", rs1_data, exp_read(rs1_addr));
      chk("rs2_data", rs2_data, exp_read(rs2_addr));
      chk("retired_count", retired_count, m_count);
      if (m_valid) begin
        chk("wb_data", wb_data, m_val);
        chk("wb_dest_reg", {27'd0, wb_dest_reg}, {27'd0, m_dest});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input bit v, input bit rw, input bit m2r, input logic [4:0] d,
                       input logic [31:0] rd, input logic [31:0] alu);
    in_valid = v; wb_control_signals = {rw, m2r}; destination_reg = d;
    ReadData = rd; AluResult = alu; stall = 0; flush = 0;
  endtask

  initial begin
    rst = 1; stall = 0; flush = 0; rs1_addr = 0; rs2_addr = 0;
    drive(0, 0, 0, 0, 0, 0);
    model_reset();
    #1;
    chk("reset wb_reg_write", {31'd0, wb_reg_write}, 32'd0);
    chk("reset wb_data", wb_data, 32'd0);
    chk("reset wb_dest_reg", {27'd0, wb_dest_reg}, 32'd0);
    chk("reset retired_count", retired_count, 32'd0);
    step(); step();
    rst = 0;
    chk_en = 1;

    // ALU write-back
    drive(1, 1, 0, 5'd5, 32'hAAAA_0000, 32'h0000_1234);
    step();
    drive(0, 0, 0, 0, 0, 0); rs1_addr = 5;
    #1;
    chk("alu wb_data", wb_data, 32'h0000_1234);
    chk("alu bypass rs1", rs1_data, 32'h0000_1234);
    chk("alu wb_reg_write", {31'd0, wb_reg_write}, 32'd1);
    step();
    #1;
    chk("alu array rs1", rs1_data, 32'h0000_1234);
    chk("alu retired", retired_count, 32'd1);

    // Load write-back
    drive(1, 1, 1, 5'd7, 32'hDEAD_BEEF, 32'h0000_0040);
    step();
    drive(0, 0, 0, 0, 0, 0); rs2_addr = 7;
    #1;
    chk("load wb_data", wb_data, 32'hDEAD_BEEF);
    chk("load bypass rs2", rs2_data, 32'hDEAD_BEEF);
    step();
    #1;
    chk("load array rs2", rs2_data, 32'hDEAD_BEEF);
    chk("load retired", retired_count, 32'd2);

    // x0 protection
    drive(1, 1, 0, 5'd0, 32'h0, 32'hFFFF_FFFF);
    step();
    drive(0, 0, 0, 0, 0, 0); rs1_addr = 0;
    #1;
    chk("x0 wb_reg_write", {31'd0, wb_reg_write}, 32'd0);
    chk("x0 rs1", rs1_data, 32'd0);
    step();
    #1;
    chk("x0 retired", retired_count, 32'd3);

    // Stall then release with flush
    drive(1, 1, 0, 5'd3, 32'h0, 32'h0000_0011);
    step();
    drive(1, 1, 0, 5'd9, 32'h0, 32'h0000_0099); stall = 1; rs1_addr = 3; rs2_addr = 9;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall wb_reg_write", {31'd0, wb_reg_write}, 32'd0);
      chk("stall rs1", rs1_data, 32'd0);
      chk("stall wb_data", wb_data, 32'h0000_0011);
      step();
      chk("stall retired", retired_count, 32'd3);
    end
    stall = 0; flush = 1;
    #1;
    chk("flush wb_reg_write", {31'd0, wb_reg_write}, 32'd1);
    chk("flush bypass rs1", rs1_data, 32'h0000_0011);
    step();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("flush retired", retired_count, 32'd4);
    chk("flush bubble", {31'd0, wb_reg_write}, 32'd0);
    step();
    #1;
    chk("bubble retired", retired_count, 32'd4);
    chk("flushed r9", rs2_data, 32'd0);
    chk("r3 kept", rs1_data, 32'h0000_0011);

    // Counter wrap
    force dut.retired_q = 32'hFFFF_FFFF;
    #1;
    release dut.retired_q;
    m_count = 32'hFFFF_FFFF;
    drive(1, 0, 0, 5'd1, 32'h0, 32'h5);
    step();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("pre-wrap retired", retired_count, 32'hFFFF_FFFF);
    step();
    #1;
    chk("wrap retired", retired_count, 32'd0);

    // Asynchronous reset with registers nonzero, no clock edge
    rs1_addr = 5; rs2_addr = 7;
    #1;
    chk("pre-reset rs1", rs1_data, 32'h0000_1234);
    rst = 1;
    #1;
    model_reset();
    chk("async rst rs1", rs1_data, 32'd0);
    chk("async rst rs2", rs2_data, 32'd0);
    chk("async rst retired", retired_count, 32'd0);
    chk("async rst wb_reg_write", {31'd0, wb_reg_write}, 32'd0);
    step();
    rst = 0;

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      in_valid           = ($urandom_range(0, 3) != 0);
      wb_control_signals = 2'($urandom_range(0, 3));
      destination_reg    = 5'($urandom_range(0, 31));
      ReadData           = $urandom;
      AluResult          = $urandom;
      stall              = ($urandom_range(0, 4) == 0);
      flush              = ($urandom_range(0, 9) == 0);
      rs1_addr           = ($urandom_range(0, 1) != 0) ? m_dest : 5'($urandom_range(0, 31));
      rs2_addr           = ($urandom_range(0, 1) != 0) ? m_dest : 5'($urandom_range(0, 31));
      if ($urandom_range(0, 499) == 0) begin
        rst = 1;
        #1;
        model_reset();
        step();
        rst = 0;
      end else begin
        step();
      end
    end

    @(negedge clk);
    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Write-back stage of the 5-stage RISC pipeline, directly downstream of the memory stage. It registers the memory stage outputs in a MEM/WB pipeline register and selects the write-back value (load data or ALU result). It owns the 32x32 architectural register file, which has two combinational read ports with same-cycle write bypass for the decode stage. It also exports write-back info for the forwarding unit and keeps a retired-instruction counter.

## Interface
- word_size, 32, data/address width
- reg_size, 5, register index width (2**reg_size registers)
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- ReadData  input  word_size  load data from memory stage
- AluResult  input  word_size  ALU result passed through memory stage
- destination_reg  input  reg_size  destination register index
- wb_control_signals  input  2  {RegWrite, MemtoReg}
- in_valid  input  1  memory stage holds a real instruction (0 = bubble)
- stall  input  1  hold MEM/WB register, suppress commit
- flush  input  1  load bubble into MEM/WB register
- rs1_addr, rs2_addr  input  reg_size  decode-stage read addresses
- rs1_data, rs2_data  output  word_size  read data (bypassed)
- wb_reg_write  output  1  committing write this cycle (to forwarding unit)
- wb_dest_reg  output  reg_size  registered destination index
- wb_data  output  word_size  selected write-back value
- retired_count  output  32  committed instruction count

## Operation
- MEM/WB register holds valid_q, RegWrite_q, MemtoReg_q, dest_q, rdata_q, alu_q.
- Priority at each rising edge: rst > flush > stall > capture.
  - flush=1: valid_q<=0, RegWrite_q<=0; other fields don't-care.
  - stall=1 (flush=0): all MEM/WB fields hold.
  - otherwise: capture all inputs; valid_q<=in_valid, RegWrite_q<=RegWrite & in_valid.
- wb_data = MemtoReg_q ? rdata_q : alu_q (combinational).
- commit = valid_q & ~stall.
- wb_reg_write = commit & RegWrite_q & (dest_q != 0); wb_dest_reg = dest_q.
- Register file: at rising edge, if wb_reg_write, regs[dest_q] <= wb_data. Register 0 is never written and always reads 0.
- Read ports are combinational. If wb_reg_write and rsX_addr == dest_q and rsX_addr != 0, rsX_data = wb_data (write-before-read bypass). Otherwise rsX_data = regs[rsX_addr]; address 0 returns 0.
- retired_count increments by 1 on each edge where commit=1, including non-writing instructions. Wraps 0xFFFFFFFF -> 0.
- Flush and commit in the same cycle: the instruction already in MEM/WB commits; the incoming one is discarded.

## Timing
- Reset (async, immediate): valid_q=0, all MEM/WB fields 0, all 32 registers 0, retired_count=0. Outputs then read wb_reg_write=0, wb_dest_reg=0, wb_data=0, rs1_data=rs2_data=0.
- Latency: inputs sampled at edge N are visible on wb_data/wb_reg_write during cycle N..N+1. The register file is updated at edge N+1, and so is retired_count.
- The read bypass makes the value written at edge N+1 visible on rs ports during cycle N..N+1 (zero-cycle hazard for the decode stage).
- Stall held K cycles: no write, no count, and outputs stay stable. The commit happens on the first edge with stall=0, together with capture of new inputs.
- rst asserted mid-stall or mid-write: the pending write is lost and all state is cleared.

## Test plan
- Reset: drive rst=1 mid-cycle with registers previously nonzero -> all rs reads 0, retired_count=0, wb_reg_write=0, with no clock edge required.
- ALU write-back: AluResult=0x0000_1234, dest=5, wb={1,0}, in_valid=1 at edge 0 -> wb_data=0x1234 and rs1_addr=5 reads 0x1234 (bypass) in cycle 0..1. regs[5]=0x1234 after edge 1; retired_count=1.
- Load write-back: ReadData=0xDEAD_BEEF, AluResult=0x40, dest=7, wb={1,1} -> regs[7]=0xDEADBEEF; rs2_addr=7 returns it via bypass, then from the array.
- x0 protection: dest=0, RegWrite=1, AluResult=0xFFFF_FFFF -> wb_reg_write=0, rs1_addr=0 reads 0, retired_count still increments.
- Stall/flush: capture dest=3 value 0x11, then hold stall=1 for 3 cycles -> no write and no count. Release stall with flush=1 -> regs[3]=0x11, count+1, next MEM/WB is a bubble (no write, no count next edge).
- Counter wrap: force retired_count to 0xFFFF_FFFF, commit one instruction -> retired_count=0.
